// File: rtl/iob_gpio_sensor_sched_pkg.sv
// Shared definitions for the sensor scheduler.
// Holds the FSM encoding, the select-width helper and the minimum window length.
package iob_gpio_sensor_sched_pkg;

   localparam int STATE_W = 2;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE  = 2'd0,
      ST_CLR   = 2'd1,
      ST_MEAS  = 2'd2,
      ST_LATCH = 2'd3
   } state_e;

   // A zero window length from software is promoted to this value.
   localparam int MIN_WIN = 1;

   function automatic int calc_sel_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/iob_gpio_sched_next_ch.sv
// Channel picker: from a channel mask, finds the lowest enabled channel and
// the next enabled channel strictly above the current select.
module iob_gpio_sched_next_ch
   import iob_gpio_sensor_sched_pkg::*;
#(
   parameter int N_SENS = 2,
   parameter int SEL_W  = 1
) (
   input  logic [N_SENS-1:0] mask_i,
   input  logic [SEL_W-1:0]  cur_sel_i,
   output logic [SEL_W-1:0]  next_sel_o,
   output logic              has_next_o,
   output logic [SEL_W-1:0]  lowest_sel_o
);

   // Scan from the top down so the last hit is the smallest qualifying index.
   always_comb begin
      next_sel_o   = '0;
      has_next_o   = 1'b0;
      lowest_sel_o = '0;
      for (int i = N_SENS - 1; i >= 0; i--) begin
         if (mask_i[i]) begin
            lowest_sel_o = SEL_W'(i);
            if (i > int'(cur_sel_i)) begin
               next_sel_o = SEL_W'(i);
               has_next_o = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/iob_gpio_sensor_sched.sv
// Time-shares one sensor-latch core across N_SENS inputs: per enabled channel it
// clears the core, runs a programmable measurement window, then latches Q.
module iob_gpio_sensor_sched
   import iob_gpio_sensor_sched_pkg::*;
#(
   parameter int N_SENS = 2,
   parameter int CNT_W  = 20,
   parameter int SEL_W  = calc_sel_w(N_SENS),
   parameter int SWP_W  = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start_i,
   input  logic               stop_i,
   input  logic               cont_i,
   input  logic [N_SENS-1:0]  ch_mask_i,
   input  logic [CNT_W-1:0]   win_len_i,
   input  logic               core_q_i,
   output logic [SEL_W-1:0]   core_sel_o,
   output logic               core_en_o,
   output logic               core_rst_o,
   output logic [N_SENS-1:0]  result_o,
   output logic [N_SENS-1:0]  result_valid_o,
   output logic               busy_o,
   output logic               done_o,
   output logic [SWP_W-1:0]   sweep_cnt_o,
   output logic [STATE_W-1:0] state_dbg_o
);

   // start_i and stop_i are single-cycle request pulses with no ready: start is
   // honoured only in IDLE with a non-zero mask, stop only while a run is busy.
   state_e              state_q, state_d;
   logic [SEL_W-1:0]    sel_q, sel_d;
   logic [N_SENS-1:0]   mask_q, mask_d;
   logic [CNT_W-1:0]    win_q, win_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                cont_q, cont_d;
   logic                stop_pend_q, stop_pend_d;
   logic [N_SENS-1:0]   result_q, result_d;
   logic [N_SENS-1:0]   valid_q, valid_d;
   logic                done_q, done_d;
   logic [SWP_W-1:0]    sweep_q, sweep_d;

   logic [N_SENS-1:0]   pick_mask;
   logic [SEL_W-1:0]    next_sel;
   logic                has_next;
   logic [SEL_W-1:0]    lowest_sel;

   // In IDLE the picker looks at the incoming mask to choose the first channel.
   assign pick_mask = (state_q == ST_IDLE) ? ch_mask_i : mask_q;

   iob_gpio_sched_next_ch #(
      .N_SENS (N_SENS),
      .SEL_W  (SEL_W)
   ) u_next_ch (
      .mask_i       (pick_mask),
      .cur_sel_i    (sel_q),
      .next_sel_o   (next_sel),
      .has_next_o   (has_next),
      .lowest_sel_o (lowest_sel)
   );

   always_comb begin
      state_d     = state_q;
      sel_d       = sel_q;
      mask_d      = mask_q;
      win_d       = win_q;
      cnt_d       = cnt_q;
      cont_d      = cont_q;
      stop_pend_d = stop_pend_q;
      result_d    = result_q;
      valid_d     = valid_q;
      done_d      = 1'b0;
      sweep_d     = sweep_q;
      case (state_q)
         ST_IDLE: begin
            if (start_i && (ch_mask_i != '0)) begin
               mask_d      = ch_mask_i;
               win_d       = (win_len_i == '0) ? CNT_W'(MIN_WIN) : win_len_i;
               cont_d      = cont_i;
               valid_d     = '0;
               stop_pend_d = 1'b0;
               sel_d       = lowest_sel;
               state_d     = ST_CLR;
            end
         end
         ST_CLR: begin
            cnt_d   = win_q - CNT_W'(1);
            state_d = ST_MEAS;
         end
         ST_MEAS: begin
            if (cnt_q == '0) state_d = ST_LATCH;
            else             cnt_d   = cnt_q - CNT_W'(1);
         end
         ST_LATCH: begin
            result_d[sel_q] = core_q_i;
            valid_d[sel_q]  = 1'b1;
            // A stop abandons the rest of the sweep and does not count it.
            if (stop_pend_q || stop_i) begin
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end else if (has_next) begin
               sel_d   = next_sel;
               state_d = ST_CLR;
            end else begin
               done_d  = 1'b1;
               sweep_d = sweep_q + SWP_W'(1);
               if (cont_q) begin
                  sel_d   = lowest_sel;
                  state_d = ST_CLR;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (stop_i && (state_q != ST_IDLE)) stop_pend_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         sel_q       <= '0;
         mask_q      <= '0;
         win_q       <= '0;
         cnt_q       <= '0;
         cont_q      <= 1'b0;
         stop_pend_q <= 1'b0;
         result_q    <= '0;
         valid_q     <= '0;
         done_q      <= 1'b0;
         sweep_q     <= '0;
      end else begin
         state_q     <= state_d;
         sel_q       <= sel_d;
         mask_q      <= mask_d;
         win_q       <= win_d;
         cnt_q       <= cnt_d;
         cont_q      <= cont_d;
         stop_pend_q <= stop_pend_d;
         result_q    <= result_d;
         valid_q     <= valid_d;
         done_q      <= done_d;
         sweep_q     <= sweep_d;
      end
   end

   assign core_sel_o     = sel_q;
   assign core_en_o      = (state_q == ST_MEAS);
   assign core_rst_o     = (state_q == ST_CLR);
   assign busy_o         = (state_q != ST_IDLE);
   assign done_o         = done_q;
   assign result_o       = result_q;
   assign result_valid_o = valid_q;
   assign sweep_cnt_o    = sweep_q;
   assign state_dbg_o    = state_q;

endmodule

// File: tb/tb_iob_gpio_sensor_sched.sv
// Self-checking bench for iob_gpio_sensor_sched: a slot-based behavioural model
// plus directed timing checks and a randomized run.
module tb_iob_gpio_sensor_sched;

   localparam int N  = 2;
   localparam int CW = 20;

   logic          clk = 1'b0;
   logic          rst;
   logic          start_i, stop_i, cont_i;
   logic [N-1:0]  ch_mask_i;
   logic [CW-1:0] win_len_i;
   logic          core_q_i = 1'b0;
   logic          core_sel_o;
   logic          core_en_o, core_rst_o;
   logic [N-1:0]  result_o, result_valid_o;
   logic          busy_o, done_o;
   logic [15:0]   sweep_cnt_o;
   logic [1:0]    state_dbg_o;

   iob_gpio_sensor_sched #(.N_SENS(N), .CNT_W(CW)) dut (
      .clk            (clk),
      .rst            (rst),
      .start_i        (start_i),
      .stop_i         (stop_i),
      .cont_i         (cont_i),
      .ch_mask_i      (ch_mask_i),
      .win_len_i      (win_len_i),
      .core_q_i       (core_q_i),
      .core_sel_o     (core_sel_o),
      .core_en_o      (core_en_o),
      .core_rst_o     (core_rst_o),
      .result_o       (result_o),
      .result_valid_o (result_valid_o),
      .busy_o         (busy_o),
      .done_o         (done_o),
      .sweep_cnt_o    (sweep_cnt_o),
      .state_dbg_o    (state_dbg_o)
   );

   // ---------------- clock / reset ----------------
   initial forever #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_vec = 0;
   int n_err = 0;
   logic chk_on = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // A run is a list of slots, one per enabled channel, each W+2 cycles long:
   // offset 0 clears, offsets 1..W measure, offset W+1 latches.
   logic         m_busy, m_cont, m_stop, m_done;
   logic [N-1:0] m_mask, m_res, m_val;
   int           m_sel, m_win, m_off;
   logic [15:0]  m_sweep;
   logic [3:0]   exp_q[$];

   function automatic int lowest_ch(input logic [N-1:0] m);
      for (int i = 0; i < N; i++) if (m[i]) return i;
      return -1;
   endfunction

   function automatic int higher_ch(input logic [N-1:0] m, input int s);
      for (int i = s + 1; i < N; i++) if (m[i]) return i;
      return -1;
   endfunction

   task automatic model_reset();
      m_busy = 0; m_cont = 0; m_stop = 0; m_done = 0;
      m_mask = '0; m_res = '0; m_val = '0;
      m_sel = 0; m_win = 0; m_off = 0; m_sweep = '0;
      exp_q.delete();
   endtask

   task automatic model_step();
      int nxt;
      m_done = 0;
      if (!m_busy) begin
         if (start_i && ch_mask_i != '0) begin
            m_busy = 1; m_mask = ch_mask_i; m_cont = cont_i; m_stop = 0;
            m_win  = (win_len_i == '0) ? 1 : int'(win_len_i);
            m_val  = '0; m_sel = lowest_ch(ch_mask_i); m_off = 0;
         end
      end else begin
         if (stop_i) m_stop = 1;
         if (m_off == m_win + 1) begin
            m_res[m_sel] = core_q_i;
            m_val[m_sel] = 1'b1;
            nxt = higher_ch(m_mask, m_sel);
            if (m_stop) begin
               m_busy = 0; m_done = 1;
            end else if (nxt >= 0) begin
               m_sel = nxt; m_off = 0;
            end else begin
               m_sweep = m_sweep + 16'd1; m_done = 1;
               if (m_cont) begin m_sel = lowest_ch(m_mask); m_off = 0; end
               else m_busy = 0;
            end
            if (m_done) exp_q.push_back({m_val, m_res});
         end else begin
            m_off++;
         end
      end
   endtask

   always @(posedge clk or negedge rst) begin
      if (!rst) model_reset();
      else      model_step();
   end

   // ---------------- compare process + scoreboard ----------------
   always @(negedge clk) begin
      logic [1:0] exp_st;
      logic [3:0] e;
      if (rst && chk_on) begin
         exp_st = !m_busy ? 2'd0 : (m_off == 0 ? 2'd1 : (m_off <= m_win ? 2'd2 : 2'd3));
         chk("core_sel", core_sel_o, m_sel);
         chk("core_en", core_en_o, m_busy && m_off >= 1 && m_off <= m_win);
         chk("core_rst", core_rst_o, m_busy && m_off == 0);
         chk("busy", busy_o, m_busy);
         chk("done", done_o, m_done);
         chk("result", result_o, m_res);
         chk("result_valid", result_valid_o, m_val);
         chk("sweep_cnt", sweep_cnt_o, m_sweep);
         chk("state_dbg", state_dbg_o, exp_st);
         if (done_o) begin
            if (exp_q.size() == 0) begin
               n_vec++; n_err++;
               $display("FAIL sb_done: done_o high with no expected sweep end (t=%0t)", $time);
            end else begin
               e = exp_q.pop_front();
               chk("sb_result", {result_valid_o, result_o}, e);
            end
         end
      end
   end

   // ---------------- monitor ----------------
   int   en_cnt = 0, rst_cnt = 0, busy_cnt = 0, done_cnt = 0, done_cyc = 0;
   logic sel_seq[$];
   always @(negedge clk) begin
      #1;
      if (core_en_o) en_cnt++;
      if (core_rst_o) begin rst_cnt++; sel_seq.push_back(core_sel_o); end
      if (busy_o) busy_cnt++;
      if (done_o) begin done_cnt++; done_cyc = cyc; end
   end

   // ---------------- driver ----------------
   int   q_mode = 1;  // 0 random, 1 fixed, 2 high only for channel 1
   logic q_fix  = 1'b0;
   always @(negedge clk) begin
      case (q_mode)
         0:       core_q_i = 1'($urandom_range(0, 1));
         1:       core_q_i = q_fix;
         default: core_q_i = (core_sel_o == 1'b1);
      endcase
   end

   int t0, b_en, b_rst, b_busy, b_done, b_sel;

   task automatic snap();
      b_en = en_cnt; b_rst = rst_cnt; b_busy = busy_cnt; b_done = done_cnt; b_sel = sel_seq.size();
   endtask

   task automatic pulse_start(input logic [N-1:0] m, input int w, input logic c, input logic s);
      @(negedge clk);
      ch_mask_i = m; win_len_i = CW'(w); cont_i = c; start_i = 1'b1; stop_i = s;
      @(negedge clk);
      start_i = 1'b0; stop_i = 1'b0; t0 = cyc;
   endtask

   task automatic wait_idle(input int budget, input string name);
      for (int i = 0; i < budget && m_busy; i++) @(negedge clk);
      if (m_busy) begin
         n_vec++; n_err++;
         $display("FAIL %s_timeout: run still busy after %0d cycles", name, budget);
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic apply_reset();
      @(negedge clk); rst = 1'b0;
      repeat (2) @(negedge clk); rst = 1'b1;
   endtask

   // ---------------- directed + random stimulus ----------------
   initial begin
      rst = 1'b0; start_i = 0; stop_i = 0; cont_i = 0; ch_mask_i = '0; win_len_i = '0;
      repeat (3) @(negedge clk);
      rst = 1'b1; chk_on = 1'b1;
      @(negedge clk);
      chk("reset_busy", busy_o, 0);
      chk("reset_en", core_en_o, 0);
      chk("reset_valid", result_valid_o, 0);
      chk("reset_sweep", sweep_cnt_o, 0);

      // T1: one channel, window 4
      q_mode = 1; q_fix = 1'b1; snap();
      pulse_start(2'b01, 4, 1'b0, 1'b0);
      wait_idle(50, "t1");
      chk("t1_clr_cycles", rst_cnt - b_rst, 1);
      chk("t1_en_cycles", en_cnt - b_en, 4);
      chk("t1_done_cycle", done_cyc - t0 + 1, 7);
      chk("t1_done_pulses", done_cnt - b_done, 1);
      chk("t1_result", result_o, 2'b01);
      chk("t1_valid", result_valid_o, 2'b01);
      chk("t1_busy", busy_o, 0);
      chk("t1_sweep", sweep_cnt_o, 1);

      // T2: two channels, window 3, Q differs per channel
      q_mode = 2; snap();
      pulse_start(2'b11, 3, 1'b0, 1'b0);
      wait_idle(60, "t2");
      chk("t2_n_channels", sel_seq.size() - b_sel, 2);
      chk("t2_first_sel", sel_seq[b_sel], 0);
      chk("t2_second_sel", sel_seq[b_sel + 1], 1);
      chk("t2_result", result_o, 2'b10);
      chk("t2_valid", result_valid_o, 2'b11);
      chk("t2_done_cycle", done_cyc - t0 + 1, 11);
      chk("t2_done_pulses", done_cnt - b_done, 1);
      chk("t2_sweep", sweep_cnt_o, 2);

      // T3: continuous sweeps, stop during a window
      apply_reset();
      q_mode = 1; q_fix = 1'b1; snap();
      pulse_start(2'b10, 2, 1'b1, 1'b0);
      for (int i = 0; i < 100 && (done_cnt - b_done) < 3; i++) @(negedge clk);
      chk("t3_three_sweeps", done_cnt - b_done, 3);
      stop_i = 1'b1;
      @(negedge clk); stop_i = 1'b0;
      wait_idle(50, "t3");
      chk("t3_sweep", sweep_cnt_o, 3);
      chk("t3_done_pulses", done_cnt - b_done, 4);
      chk("t3_en_cycles", en_cnt - b_en, 8);
      chk("t3_valid", result_valid_o, 2'b10);
      chk("t3_result", result_o, 2'b10);
      chk("t3_busy", busy_o, 0);

      // T4: zero window, empty mask, start+stop together in IDLE
      apply_reset(); snap();
      pulse_start(2'b01, 0, 1'b0, 1'b0);
      wait_idle(50, "t4a");
      chk("t4_win0_en_cycles", en_cnt - b_en, 1);
      chk("t4_win0_done", done_cnt - b_done, 1);
      snap();
      pulse_start(2'b00, 3, 1'b0, 1'b0);
      repeat (10) @(negedge clk);
      chk("t4_mask0_busy", busy_cnt - b_busy, 0);
      chk("t4_mask0_done", done_cnt - b_done, 0);
      pulse_start(2'b10, 1, 1'b0, 1'b1);
      wait_idle(50, "t4c");
      chk("t4_start_wins_sweep", sweep_cnt_o, 2);

      // T5: second start while busy is ignored
      q_mode = 2; snap();
      pulse_start(2'b11, 3, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      ch_mask_i = 2'b01; win_len_i = CW'(7); start_i = 1'b1;
      @(negedge clk); start_i = 1'b0;
      wait_idle(60, "t5");
      chk("t5_en_cycles", en_cnt - b_en, 6);
      chk("t5_done_cycle", done_cyc - t0 + 1, 11);
      chk("t5_second_sel", sel_seq[b_sel + 1], 1);
      chk("t5_sweep", sweep_cnt_o, 3);

      // T6: asynchronous reset during channel 1 measurement
      q_mode = 1; snap();
      pulse_start(2'b11, 5, 1'b0, 1'b0);
      for (int i = 0; i < 100 && !(core_sel_o == 1'b1 && core_en_o); i++) @(negedge clk);
      chk("t6_reached_ch1_meas", {core_sel_o, core_en_o}, 2'b11);
      #2 rst = 1'b0;
      #1;
      chk("t6_async_en", core_en_o, 0);
      chk("t6_async_busy", busy_o, 0);
      chk("t6_async_valid", result_valid_o, 0);
      chk("t6_async_sweep", sweep_cnt_o, 0);
      @(negedge clk); rst = 1'b1;
      q_fix = 1'b1; snap();
      pulse_start(2'b01, 4, 1'b0, 1'b0);
      wait_idle(50, "t6b");
      chk("t6_rerun_en_cycles", en_cnt - b_en, 4);
      chk("t6_rerun_done_cycle", done_cyc - t0 + 1, 7);
      chk("t6_rerun_result", {result_valid_o, result_o}, 4'b0101);
      chk("t6_rerun_sweep", sweep_cnt_o, 1);

      // Randomized traffic against the model
      q_mode = 0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         start_i   = ($urandom_range(0, 19) == 0);
         stop_i    = ($urandom_range(0, 49) == 0);
         cont_i    = 1'($urandom_range(0, 1));
         ch_mask_i = N'($urandom_range(0, 3));
         win_len_i = CW'($urandom_range(0, 5));
      end
      @(negedge clk);
      start_i = 1'b0; stop_i = 1'b1;
      @(negedge clk); stop_i = 1'b0;
      wait_idle(200, "drain");
      chk("sb_drained", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
